// File: rtl/usb_uart_pkg.sv
// Shared constants for the USB-CDC to UART byte path.
// Holds the data width, the default FIFO depth and idle timeout, and the
// helper that sizes occupancy counters.
package usb_uart_pkg;

    localparam int DATA_W              = 8;
    localparam int FIFO_DEPTH_DEFAULT  = 16;
    localparam int IDLE_CYCLES_DEFAULT = 2000000;
    localparam int IDLE_CNT_W          = 24;

    typedef logic [DATA_W-1:0] byte_t;

    // An occupancy counter must represent 0..depth inclusive, so it needs
    // one bit more than a pointer into the storage.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usb_uart_fifo_ram.sv
// Byte storage for usb_uart_fifo: synchronous write, asynchronous read,
// so the oldest byte can be presented in the same cycle it becomes the head.
module usb_uart_fifo_ram
    import usb_uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(FIFO_DEPTH_DEFAULT)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);

    byte_t mem [DEPTH];

    // Write port: store the byte on the write handshake edge.
    // NOTE: the array has no reset; stale contents are never visible because
    // the read side only looks at entries covered by the occupancy count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_uart_fifo.sv
// First-word fall-through byte FIFO between the usb_cdc out stream and the
// uart s_axis input, with an optional link-idle detector.
// Optional feature: define USB_UART_FIFO_SLEEP_EN to build the idle counter
// that drives sleep_o; otherwise sleep_o is tied low.
module usb_uart_fifo
    import usb_uart_pkg::*;
#(
    parameter int DEPTH       = FIFO_DEPTH_DEFAULT,
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [DATA_W-1:0]             m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic                          sleep_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_next;
    logic          wr_en;
    logic          rd_en;

    // Flow control comes only from the registered level, so there is no
    // combinational path from m_ready_i to s_ready_o.
    assign s_ready_o = (level != LW'(DEPTH));
    assign m_valid_o = (level != '0);
    assign level_o   = level;

    // A handshake presented while rst is high is ignored entirely.
    assign wr_en = s_valid_i & s_ready_o & ~rst;
    assign rd_en = m_valid_o & m_ready_i & ~rst;

    usb_uart_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (s_data_i),
        .raddr (rd_ptr),
        .rdata (m_data_o)
    );

    // Next occupancy: +1 on write only, -1 on read only, else unchanged.
    always_comb begin
        // NOTE: assigning the default before the case keeps every path
        // covered, so no latch is inferred.
        level_next = level;
        case ({wr_en, rd_en})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
        end
    end

`ifdef USB_UART_FIFO_SLEEP_EN
    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(IDLE_CYCLES);

    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  idle_clr;
    logic                  sleep_q;

    // Any traffic, pending request or buffered byte means the link is busy.
    assign idle_clr = wr_en | rd_en | s_valid_i | m_valid_o;

    // Idle counter: cleared by activity, otherwise counts up and saturates.
    always_ff @(posedge clk) begin
        if (rst || idle_clr) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
        end
    end

    // Sleep flag: set once the counter has saturated, dropped on activity.
    always_ff @(posedge clk) begin
        if (rst || idle_clr) begin
            sleep_q <= 1'b0;
        end else begin
            sleep_q <= (idle_cnt == IDLE_MAX);
        end
    end

    assign sleep_o = sleep_q;
`else
    assign sleep_o = 1'b0;
`endif

endmodule

// File: tb/tb_usb_uart_fifo.sv
// Self-checking bench for usb_uart_fifo: a queue-based reference model
// tracks the FIFO contents; directed and randomized traffic is compared
// against it every cycle.
module tb_usb_uart_fifo;
    import usb_uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int IDLE  = 100;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [7:0]    m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [LW-1:0] level_o;
    logic          sleep_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       did_wr;
    logic       did_rd;
    logic [7:0] popped;

    always #5 clk = ~clk;

    usb_uart_fifo #(
        .DEPTH       (DEPTH),
        .IDLE_CYCLES (IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .level_o   (level_o),
        .sleep_o   (sleep_o)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Compare all visible outputs against the model's queue.
    task automatic check_state();
        check("level", 32'(level_o), 32'(q.size()));
        check("s_ready", 32'(s_ready_o), 32'(q.size() != DEPTH));
        check("m_valid", 32'(m_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("m_data", 32'(m_data_o), 32'(q[0]));
        end
`ifndef USB_UART_FIFO_SLEEP_EN
        check("sleep_off", 32'(sleep_o), 32'(0));
`endif
    endtask

    // Check outputs, then advance one clock and update the model.
    task automatic tick();
        logic [7:0] wdata;
        check_state();
        did_wr = !rst && s_valid_i && (q.size() < DEPTH);
        did_rd = !rst && m_ready_i && (q.size() != 0);
        wdata  = s_data_i;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (did_rd) popped = q.pop_front();
            if (did_wr) q.push_back(wdata);
        end
        #1;
    endtask

    initial begin
        logic [7:0] stim [40];
        int sent;
        int rcvd;
        int cyc;

        rst       = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = 8'h00;
        m_ready_i = 1'b0;

        // Reset / empty.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_level", 32'(level_o), 32'(0));
        check("rst_m_valid", 32'(m_valid_o), 32'(0));
        check("rst_s_ready", 32'(s_ready_o), 32'(1));
        check("rst_sleep", 32'(sleep_o), 32'(0));

        // Fill with 0x00..0x0F while the consumer stalls.
        for (int i = 0; i < DEPTH; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 8'(i);
            tick();
        end
        s_data_i = 8'hEE;
        tick();
        s_valid_i = 1'b0;
        check("full_s_ready", 32'(s_ready_o), 32'(0));
        check("full_level", 32'(level_o), 32'(16));
        check("full_head", 32'(m_data_o), 32'(0));

        // Drain in order.
        m_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("drain_order", 32'(popped), 32'(i));
            if (i == 0) check("ready_after_read", 32'(s_ready_o), 32'(1));
        end
        m_ready_i = 1'b0;
        check("drain_empty", 32'(m_valid_o), 32'(0));
        check("drain_level", 32'(level_o), 32'(0));

        // Random stream of 40 bytes across several pointer wraps.
        for (int i = 0; i < 40; i++) stim[i] = 8'($urandom);
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 40 && cyc < 4000) begin
            s_valid_i = (sent < 40) && ($urandom_range(0, 3) != 0);
            s_data_i  = stim[(sent < 40) ? sent : 0];
            m_ready_i = (cyc < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            tick();
            check("wrap_level_max", 32'(level_o <= 5'd16), 32'(1));
            if (did_wr) sent++;
            if (did_rd) begin
                check("wrap_order", 32'(popped), 32'(stim[rcvd]));
                rcvd++;
            end
            cyc++;
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        check("wrap_done", 32'(rcvd), 32'(40));

        // Simultaneous read and write at level 5.
        for (int i = 0; i < 5; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 8'h10 + 8'(i);
            tick();
        end
        check("sim_pre_level", 32'(level_o), 32'(5));
        check("sim_pre_head", 32'(m_data_o), 32'(8'h10));
        s_data_i  = 8'h15;
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        s_valid_i = 1'b0;
        check("sim_level", 32'(level_o), 32'(5));
        check("sim_head", 32'(m_data_o), 32'(8'h11));

        // Mid-stream reset at level 7, with a handshake offered during reset.
        s_valid_i = 1'b1;
        s_data_i  = 8'h16;
        tick();
        s_data_i  = 8'h17;
        tick();
        check("mid_level7", 32'(level_o), 32'(7));
        rst       = 1'b1;
        s_data_i  = 8'h99;
        m_ready_i = 1'b1;
        tick();
        rst       = 1'b0;
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        check("mid_rst_level", 32'(level_o), 32'(0));
        check("mid_rst_m_valid", 32'(m_valid_o), 32'(0));
        check("mid_rst_s_ready", 32'(s_ready_o), 32'(1));
        s_valid_i = 1'b1;
        s_data_i  = 8'hA5;
        tick();
        s_valid_i = 1'b0;
        check("mid_a5_valid", 32'(m_valid_o), 32'(1));
        check("mid_a5_data", 32'(m_data_o), 32'(8'hA5));
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        check("mid_a5_pop", 32'(popped), 32'(8'hA5));

        // Idle / sleep.
        repeat (50) tick();
        check("sleep_early", 32'(sleep_o), 32'(0));
        repeat (60) tick();
`ifdef USB_UART_FIFO_SLEEP_EN
        check("sleep_set", 32'(sleep_o), 32'(1));
`else
        check("sleep_set", 32'(sleep_o), 32'(0));
`endif
        s_valid_i = 1'b1;
        s_data_i  = 8'h3C;
        tick();
        s_valid_i = 1'b0;
        check("sleep_clear", 32'(sleep_o), 32'(0));
        check("sleep_byte", 32'(m_data_o), 32'(8'h3C));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_uart_fifo.md
USB_UART_FIFO -- requirements
Module: usb_uart_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; power of two, 2..256.
REQ-002 SHALL have parameter IDLE_CYCLES, default 2000000, number of idle clocks before sleep_o asserts; range 1..2^24-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_data_i, input, 8 bits: write byte from the usb_cdc out stream.
REQ-006 SHALL have port s_valid_i, input, 1 bit: write byte valid.
REQ-007 SHALL have port s_ready_o, output, 1 bit: FIFO can accept a byte.
REQ-008 SHALL have port m_data_o, output, 8 bits: read byte to the uart s_axis.
REQ-009 SHALL have port m_valid_o, output, 1 bit: read byte valid.
REQ-010 SHALL have port m_ready_i, input, 1 bit: consumer accepts the byte.
REQ-011 SHALL have port level_o, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have port sleep_o, output, 1 bit: link idle indication.

Function
REQ-013 SHALL perform a write when s_valid_i and s_ready_o are both high on a rising edge.
REQ-014 SHALL perform a read when m_valid_o and m_ready_i are both high on a rising edge.
REQ-015 SHALL drive s_ready_o = (level_o != DEPTH), purely from registered state, with no combinational path from m_ready_i.
REQ-016 SHALL drive m_valid_o = (level_o != 0) and present the oldest byte on m_data_o (first-word fall-through).
REQ-017 SHALL have 1-cycle latency: a byte written at edge N drives m_valid_o high after edge N.
REQ-018 SHALL hold m_data_o stable while m_valid_o is high and m_ready_i is low.
REQ-019 SHALL update level_o as follows: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-020 SHALL wrap the read and write pointers (clog2(DEPTH) bits each) modulo DEPTH, with no gap or duplicate at the wrap.
REQ-021 SHALL allow a simultaneous write and read when 0 < level_o < DEPTH, preserving order.
REQ-022 SHALL, when full, accept no write (s_ready_o low) but allow a read; s_ready_o rises on the edge after the read.
REQ-023 SHALL, when empty, accept no read (m_valid_o low); the written byte becomes visible on the next cycle.
REQ-024 SHALL never change s_data_i or m_data_o contents outside a handshake; it SHALL never drop or corrupt a byte.

Reset
REQ-025 SHALL, on rst high at a rising edge, set pointers and level_o to 0, giving m_valid_o=0, s_ready_o=1 (the cycle after), and sleep_o=0.
REQ-026 SHALL discard FIFO contents on reset asserted mid-stream; the storage array is not cleared and m_data_o is don't-care while m_valid_o=0.
REQ-027 SHALL ignore any handshake presented in a cycle where rst is high.

Configuration
REQ-028 SHALL compile in, when macro USB_UART_FIFO_SLEEP_EN is defined, a 24-bit idle counter that resets to 0 on any write, any read, s_valid_i high, or level_o != 0, and otherwise increments, saturating at IDLE_CYCLES.
REQ-029 SHALL, with USB_UART_FIFO_SLEEP_EN defined, register sleep_o high when the counter equals IDLE_CYCLES, and drive it low on the edge after any clearing event.
REQ-030 SHALL, with USB_UART_FIFO_SLEEP_EN undefined, tie sleep_o constant 0 and instantiate no counter logic.

Structure
REQ-031 SHALL take DATA_W=8 and default DEPTH/IDLE_CYCLES from shared package usb_uart_pkg, together with the level-width helper function.
REQ-032 SHALL contain one sub-module, usb_uart_fifo_ram: DEPTH x 8 storage with synchronous write and asynchronous read; all control logic stays in the top of usb_uart_fifo.

Verification
REQ-033 SHALL pass a reset/empty test: assert rst for 2 cycles -> level_o=0, m_valid_o=0, s_ready_o=1, sleep_o=0.
REQ-034 SHALL pass a fill/drain test with DEPTH=16 and m_ready_i=0: write 0x00..0x0F -> s_ready_o=0 with level_o=16; then m_ready_i=1 -> 0x00..0x0F out in order, then m_valid_o=0.
REQ-035 SHALL pass a full-pointer wrap test: stream 40 bytes with random s_valid_i/m_ready_i -> output sequence identical to input, level_o never above 16.
REQ-036 SHALL pass a simultaneous read/write test at level_o=5: write and read on the same edge -> level_o stays 5 and the head byte advances.
REQ-037 SHALL pass a mid-stream reset test: reset at level_o=7 -> level_o=0 next cycle, then a fresh 0xA5 write is the first byte out.
REQ-038 SHALL pass an idle/sleep test with the macro defined and IDLE_CYCLES=100: 100 idle clocks -> sleep_o=1; then s_valid_i=1 -> sleep_o=0 next cycle; with the macro undefined -> sleep_o=0 throughout.
